// File: rtl/aes_ctr_axis_mc_pkg.sv
// Shared types and helpers for the multi-core AES-CTR stream engine.
package aes_ctr_pkg;
    localparam int BLOCK_W = 128;
    localparam int KEEP_W  = 16;

    typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

    // Mask covering the low ctr_w bits that take part in the increment
    function automatic logic [BLOCK_W-1:0] ctr_low_mask(input int ctr_w);
        logic [BLOCK_W-1:0] m;
        if (ctr_w >= BLOCK_W) m = '1;
        else                  m = (BLOCK_W'(1) << ctr_w) - BLOCK_W'(1);
        return m;
    endfunction

    function automatic logic [BLOCK_W-1:0] ctr_inc(input logic [BLOCK_W-1:0] blk, input int ctr_w);
        logic [BLOCK_W-1:0] m;
        m = ctr_low_mask(ctr_w);
        return (blk & ~m) | ((blk + BLOCK_W'(1)) & m);
    endfunction

    function automatic logic [BLOCK_W-1:0] keep_mask(input logic [KEEP_W-1:0] keep);
        logic [BLOCK_W-1:0] m;
        m = '0;
        for (int k = 0; k < KEEP_W; k++) m[8*k +: 8] = {8{keep[k]}};
        return m;
    endfunction
endpackage

// File: rtl/aes_ctr_axis_mc_if.sv
// AXI4-Stream bundle used on both sides of the engine.
interface aes_ctr_axis_mc_if;
    import aes_ctr_pkg::*;
    logic [BLOCK_W-1:0] tdata;
    logic [KEEP_W-1:0]  tkeep;
    logic               tlast;
    logic               tvalid;
    logic               tready;
    modport master (output tdata, tkeep, tlast, tvalid, input tready);
    modport slave  (input tdata, tkeep, tlast, tvalid, output tready);
endinterface

// File: rtl/aes_core.sv
// Iterative AES-128 encryptor: one round per cycle, round keys expanded on the fly.
module aes_core (
    input  logic         aclk,
    input  logic         aresetn,
    input  logic [127:0] key,
    input  logic [127:0] block_in,
    input  logic         start,
    output logic [127:0] block_out,
    output logic         valid,
    output logic         busy
);
    logic [127:0] st, rk, nk, nst;
    logic [7:0]   rcon;
    logic [3:0]   round;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // S-box as GF(2^8) inverse (a^254) followed by the affine transform
    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] p, s;
        s = a;
        p = 8'h01;
        for (int i = 1; i < 8; i++) begin
            s = gmul(s, s);
            p = gmul(p, s);
        end
        return p ^ {p[6:0], p[7]} ^ {p[5:0], p[7:6]} ^ {p[4:0], p[7:5]} ^ {p[3:0], p[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [127:0] key_next(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] w0, w1, w2, w3, t;
        {w0, w1, w2, w3} = k;
        t  = {sbox(w3[23:16]) ^ rc, sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])};
        w0 = w0 ^ t;
        w1 = w1 ^ w0;
        w2 = w2 ^ w1;
        w3 = w3 ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    // Byte n of a block is bits [127-8n -: 8]; state is column-major
    function automatic logic [127:0] round_fn(input logic [127:0] s, input logic [127:0] k, input logic last);
        logic [7:0]   sb [16];
        logic [7:0]   sr [16];
        logic [7:0]   a0, a1, a2, a3;
        logic [127:0] o;
        for (int n = 0; n < 16; n++) sb[n] = sbox(s[127-8*n -: 8]);
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) sr[r+4*c] = sb[r + 4*((c+r) % 4)];
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = sr[4*c]; a1 = sr[4*c+1]; a2 = sr[4*c+2]; a3 = sr[4*c+3];
            if (last) begin
                o[127-32*c -: 32] = {a0, a1, a2, a3};
            end else begin
                o[127-32*c -: 32] = {xtime(a0) ^ gmul(a1, 8'h03) ^ a2 ^ a3,
                                     a0 ^ xtime(a1) ^ gmul(a2, 8'h03) ^ a3,
                                     a0 ^ a1 ^ xtime(a2) ^ gmul(a3, 8'h03),
                                     gmul(a0, 8'h03) ^ a1 ^ a2 ^ xtime(a3)};
            end
        end
        return o ^ k;
    endfunction

    assign nk  = key_next(rk, rcon);
    assign nst = round_fn(st, nk, round == 4'd10);

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            st <= '0; rk <= '0; rcon <= '0; round <= '0;
            busy <= 1'b0; valid <= 1'b0; block_out <= '0;
        end else begin
            valid <= 1'b0;
            if (start && !busy) begin
                st    <= block_in ^ key;
                rk    <= key;
                rcon  <= 8'h01;
                round <= 4'd1;
                busy  <= 1'b1;
            end else if (busy) begin
                st    <= nst;
                rk    <= nk;
                rcon  <= xtime(rcon);
                round <= round + 4'd1;
                if (round == 4'd10) begin
                    busy      <= 1'b0;
                    valid     <= 1'b1;
                    block_out <= nst;
                end
            end
        end
    end
endmodule

// File: rtl/aes_ctr_axis_mc_lane.sv
// One keystream lane: an aes_core plus a single-entry keystream buffer.
module aes_ctr_lane
    import aes_ctr_pkg::*;
(
    input  logic               aclk,
    input  logic               aresetn,
    input  logic [BLOCK_W-1:0] key,
    input  logic               dispatch,
    input  logic [BLOCK_W-1:0] ctr_blk,
    input  logic               consume,
    input  logic               flush,
    input  logic               drop,
    output logic [BLOCK_W-1:0] ks,
    output logic               ks_full,
    output logic               avail,
    output logic               core_busy
);
    logic [BLOCK_W-1:0] core_out;
    logic               core_valid;

    aes_core u_core (
        .aclk      (aclk),
        .aresetn   (aresetn),
        .key       (key),
        .block_in  (ctr_blk),
        .start     (dispatch),
        .block_out (core_out),
        .valid     (core_valid),
        .busy      (core_busy)
    );

    // A result being written this cycle still occupies the lane
    assign avail = !core_busy && !core_valid && !ks_full;

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            ks      <= '0;
            ks_full <= 1'b0;
        end else if (flush) begin
            ks_full <= 1'b0;
        end else if (core_valid && !drop) begin
            ks      <= core_out;
            ks_full <= 1'b1;
        end else if (consume) begin
            ks_full <= 1'b0;
        end
    end
endmodule

// File: rtl/aes_ctr_axis_mc.sv
// Multi-core AES-CTR AXI4-Stream engine: round-robin keystream prefetch, in-order XOR.
module aes_ctr_axis_mc
    import aes_ctr_pkg::*;
#(
    parameter int NUM_CORES      = 2,
    parameter int CTR_W          = 32,
    parameter int RELOAD_ON_LAST = 0
) (
    input  logic               aclk,
    input  logic               aresetn,
    input  logic [BLOCK_W-1:0] key,
    input  logic [BLOCK_W-1:0] iv,
    input  logic               keyiv_valid,
    input  logic               start,
    input  logic               abort,
    aes_ctr_axis_mc_if.slave   s_axis,
    aes_ctr_axis_mc_if.master  m_axis,
    output logic               busy,
    output logic               err_start,
    output logic               ctr_wrap,
    output logic [31:0]        blk_count
);
    localparam int                 PW       = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
    localparam logic [BLOCK_W-1:0] LOW_MASK = ctr_low_mask(CTR_W);

    state_t                            state, state_nxt;
    logic [BLOCK_W-1:0]                key_q, iv_q, ctr;
    logic [PW-1:0]                     d_ptr, r_ptr;
    logic [NUM_CORES-1:0]              ks_full, avail, core_busy;
    logic [NUM_CORES-1:0][BLOCK_W-1:0] ks;
    logic [BLOCK_W-1:0]                m_tdata;
    logic [KEEP_W-1:0]                 m_tkeep;
    logic                              m_tlast, m_tvalid;
    logic                              cores_idle, dispatch, in_hs, out_hs, flush_done, start_ok;

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == PW'(NUM_CORES-1)) ? '0 : p + PW'(1);
    endfunction

    assign cores_idle    = ~|core_busy;
    assign dispatch      = (state == RUN) && avail[d_ptr];
    assign s_axis.tready = (state == RUN) && ks_full[r_ptr] && (!m_tvalid || m_axis.tready);
    assign in_hs         = s_axis.tvalid && s_axis.tready;
    assign out_hs        = m_tvalid && m_axis.tready;
    assign flush_done    = (state == FLUSH) && cores_idle;
    // start is only honoured once stale in-flight blocks have left every core
    assign start_ok      = (state == IDLE) && start && cores_idle && !abort;
    assign busy          = (state != IDLE);

    assign m_axis.tdata  = m_tdata;
    assign m_axis.tkeep  = m_tkeep;
    assign m_axis.tlast  = m_tlast;
    assign m_axis.tvalid = m_tvalid;

    for (genvar i = 0; i < NUM_CORES; i++) begin : g_lane
        aes_ctr_lane u_lane (
            .aclk      (aclk),
            .aresetn   (aresetn),
            .key       (key_q),
            .dispatch  (dispatch && (d_ptr == PW'(i))),
            .ctr_blk   (ctr),
            .consume   (in_hs && (r_ptr == PW'(i))),
            .flush     (abort || flush_done),
            .drop      (state != RUN),
            .ks        (ks[i]),
            .ks_full   (ks_full[i]),
            .avail     (avail[i]),
            .core_busy (core_busy[i])
        );
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (abort) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    if (start_ok && keyiv_valid) state_nxt = RUN;
                RUN:     if ((RELOAD_ON_LAST != 0) && in_hs && s_axis.tlast) state_nxt = FLUSH;
                FLUSH:   if (cores_idle) state_nxt = RUN;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            key_q <= '0; iv_q <= '0; ctr <= '0;
            d_ptr <= '0; r_ptr <= '0;
            m_tdata <= '0; m_tkeep <= '0; m_tlast <= 1'b0; m_tvalid <= 1'b0;
            err_start <= 1'b0; ctr_wrap <= 1'b0; blk_count <= '0;
        end else begin
            if (out_hs) blk_count <= blk_count + 32'd1;

            // Output register reloads on the same edge it drains: no bubble
            if (in_hs) begin
                m_tdata  <= (s_axis.tdata ^ ks[r_ptr]) & keep_mask(s_axis.tkeep);
                m_tkeep  <= s_axis.tkeep;
                m_tlast  <= s_axis.tlast;
                m_tvalid <= 1'b1;
                r_ptr    <= ptr_next(r_ptr);
            end else if (out_hs) begin
                m_tvalid <= 1'b0;
            end

            if (dispatch) begin
                ctr   <= ctr_inc(ctr, CTR_W);
                d_ptr <= ptr_next(d_ptr);
                if ((ctr & LOW_MASK) == LOW_MASK) ctr_wrap <= 1'b1;
            end

            if (start_ok) begin
                if (keyiv_valid) begin
                    key_q     <= key;
                    iv_q      <= iv;
                    ctr       <= iv;
                    err_start <= 1'b0;
                    ctr_wrap  <= 1'b0;
                    blk_count <= '0;
                end else begin
                    err_start <= 1'b1;
                end
            end

            if (flush_done && !abort) begin
                ctr   <= iv_q;
                d_ptr <= '0;
                r_ptr <= '0;
            end

            if (abort) begin
                d_ptr    <= '0;
                r_ptr    <= '0;
                m_tvalid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_aes_ctr_axis_mc.sv
// Directed bench: SP800-38A CTR vectors on 1/2/4-core instances, stalls, reload, wrap, abort.
module tb_aes_ctr_axis_mc;
    import aes_ctr_pkg::*;

    localparam logic [127:0] KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] IV  = 128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdfeff;
    localparam logic [127:0] IVW = 128'hf0f1f2f3f4f5f6f7f8f9fafbffffffff;
    localparam logic [127:0] PT0 = 128'h6bc1bee22e409f96e93d7e117393172a;
    localparam logic [127:0] PT1 = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
    localparam logic [127:0] PT2 = 128'h30c81c46a35ce411e5fbc1191a0a52ef;
    localparam logic [127:0] PT3 = 128'hf69f2445df4f9b17ad2b417be66c3710;
    localparam logic [127:0] CT0 = 128'h874d6191b620e3261bef6864990db6ce;
    localparam logic [127:0] CT1 = 128'h9806f66b7970fdff8617187bb9fffdff;
    localparam logic [127:0] CT2 = 128'h5ae4df3edbd5d35e5b4f09020db03eab;
    localparam logic [127:0] CT3 = 128'h1e031dda2fbe03d1792170a0f3009cee;

    logic              aclk = 1'b0;
    logic              aresetn;
    logic [127:0]      key, iv;
    logic              keyiv_valid;
    logic [2:0]        start, abort, s_tlast, s_tvalid, s_tready, m_tready;
    logic [2:0]        m_tlast, m_tvalid, busy, err_start, ctr_wrap;
    logic [2:0][127:0] s_tdata, m_tdata;
    logic [2:0][15:0]  s_tkeep, m_tkeep;
    logic [2:0][31:0]  blk_count;

    logic [127:0] pt_v [4];
    logic [127:0] exp_v [4];
    logic [15:0]  keep_v [4];
    logic         last_v [4];

    int n_chk = 0;
    int n_fail = 0;

    always #5 aclk = ~aclk;

    // Instance 0: 2 cores, 1: 1 core, 2: 4 cores with per-packet reload
    for (genvar g = 0; g < 3; g++) begin : gen_dut
        aes_ctr_axis_mc_if sif ();
        aes_ctr_axis_mc_if mif ();
        assign sif.tdata   = s_tdata[g];
        assign sif.tkeep   = s_tkeep[g];
        assign sif.tlast   = s_tlast[g];
        assign sif.tvalid  = s_tvalid[g];
        assign s_tready[g] = sif.tready;
        assign mif.tready  = m_tready[g];
        assign m_tdata[g]  = mif.tdata;
        assign m_tkeep[g]  = mif.tkeep;
        assign m_tlast[g]  = mif.tlast;
        assign m_tvalid[g] = mif.tvalid;

        aes_ctr_axis_mc #(
            .NUM_CORES      ((g == 0) ? 2 : (g == 1) ? 1 : 4),
            .CTR_W          (32),
            .RELOAD_ON_LAST ((g == 2) ? 1 : 0)
        ) u_dut (
            .aclk        (aclk),
            .aresetn     (aresetn),
            .key         (key),
            .iv          (iv),
            .keyiv_valid (keyiv_valid),
            .start       (start[g]),
            .abort       (abort[g]),
            .s_axis      (sif.slave),
            .m_axis      (mif.master),
            .busy        (busy[g]),
            .err_start   (err_start[g]),
            .ctr_wrap    (ctr_wrap[g]),
            .blk_count   (blk_count[g])
        );
    end

    task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic start_session(input int idx);
        @(negedge aclk) start[idx] = 1'b1;
        @(negedge aclk) start[idx] = 1'b0;
        chk("start_busy", busy[idx], 1);
        chk("start_err", err_start[idx], 0);
    endtask

    task automatic abort_session(input int idx);
        @(negedge aclk) abort[idx] = 1'b1;
        @(negedge aclk) abort[idx] = 1'b0;
        repeat (15) @(negedge aclk);
    endtask

    task automatic load_f51();
        pt_v  = '{PT0, PT1, PT2, PT3};
        exp_v = '{CT0, CT1, CT2, CT3};
        keep_v = '{16'hffff, 16'hffff, 16'hffff, 16'hffff};
        last_v = '{1'b0, 1'b0, 1'b0, 1'b1};
    endtask

    // Streams n beats from pt_v, checks outputs in order and holds under stall
    task automatic run_stream(input int idx, input int n, input bit stall, input bit chk_data, input string tag);
        int i, o, cyc;
        bit acc, held, tr;
        logic [127:0] hd;
        logic [16:0]  hkl;
        i = 0; o = 0; cyc = 0; acc = 0; held = 0;
        while ((i < n || o < n) && cyc < 2000) begin
            @(negedge aclk);
            cyc++;
            if (acc) i++;
            acc = 0;
            if (held) begin
                chk({tag, "_stall_valid"}, m_tvalid[idx], 1);
                chk({tag, "_stall_data"}, m_tdata[idx], hd);
                chk({tag, "_stall_keeplast"}, {m_tkeep[idx], m_tlast[idx]}, hkl);
            end
            tr = stall ? ($urandom_range(0, 1) != 0) : 1'b1;
            m_tready[idx] = tr;
            if (m_tvalid[idx] && tr) begin
                if (o < n && chk_data) begin
                    chk({tag, "_data"}, m_tdata[idx], exp_v[o]);
                    chk({tag, "_keeplast"}, {m_tkeep[idx], m_tlast[idx]}, {keep_v[o], last_v[o]});
                end
                o++;
            end
            held = m_tvalid[idx] && !tr;
            hd   = m_tdata[idx];
            hkl  = {m_tkeep[idx], m_tlast[idx]};
            if (i < n) begin
                s_tvalid[idx] = 1'b1;
                s_tdata[idx]  = pt_v[i];
                s_tkeep[idx]  = keep_v[i];
                s_tlast[idx]  = last_v[i];
            end else begin
                s_tvalid[idx] = 1'b0;
            end
            #1;
            acc = s_tvalid[idx] && s_tready[idx];
        end
        chk({tag, "_beats"}, o, n);
        @(negedge aclk);
        s_tvalid[idx] = 1'b0;
        m_tready[idx] = 1'b1;
        @(negedge aclk);
        chk({tag, "_no_extra"}, m_tvalid[idx], 0);
    endtask

    initial begin
        aresetn = 1'b0; key = KEY; iv = IV; keyiv_valid = 1'b0;
        start = '0; abort = '0; s_tvalid = '0; s_tlast = '0; m_tready = '1;
        s_tdata = '0; s_tkeep = '0;
        repeat (3) @(negedge aclk);
        chk("rst_busy", busy, 0);
        chk("rst_mvalid", m_tvalid, 0);
        chk("rst_sready", s_tready, 0);
        chk("rst_flags", {err_start, ctr_wrap}, 0);
        chk("rst_count", blk_count[0], 0);
        chk("rst_tdata", m_tdata[0], 0);
        aresetn = 1'b1;
        repeat (2) @(negedge aclk);

        // start without programmed key/iv
        @(negedge aclk) start[0] = 1'b1;
        @(negedge aclk) start[0] = 1'b0;
        chk("err_start_set", err_start[0], 1);
        chk("err_busy", busy[0], 0);

        // SP800-38A F.5.1, no stalls
        keyiv_valid = 1'b1;
        start_session(0);
        load_f51();
        run_stream(0, 4, 1'b0, 1'b1, "f51");
        chk("f51_count", blk_count[0], 4);
        chk("f51_wrap", ctr_wrap[0], 0);

        // partial first beat
        abort_session(0);
        start_session(0);
        pt_v[0] = PT0; keep_v[0] = 16'h00ff; last_v[0] = 1'b1;
        exp_v[0] = 128'h0000000000000000_1bef6864990db6ce;
        run_stream(0, 1, 1'b0, 1'b1, "part");
        chk("part_count", blk_count[0], 1);

        // abort with an output beat held
        abort_session(0);
        start_session(0);
        m_tready[0] = 1'b0;
        s_tdata[0] = PT0; s_tkeep[0] = 16'hffff; s_tlast[0] = 1'b0; s_tvalid[0] = 1'b1;
        repeat (20) @(negedge aclk);
        s_tvalid[0] = 1'b0;
        chk("abort_pre_valid", m_tvalid[0], 1);
        chk("abort_pre_data", m_tdata[0], CT0);
        @(negedge aclk) abort[0] = 1'b1;
        @(negedge aclk) abort[0] = 1'b0;
        chk("abort_busy", busy[0], 0);
        chk("abort_mvalid", m_tvalid[0], 0);
        chk("abort_count", blk_count[0], 0);
        m_tready[0] = 1'b1;
        repeat (15) @(negedge aclk);
        start_session(0);
        load_f51();
        run_stream(0, 4, 1'b0, 1'b1, "restart");
        chk("restart_count", blk_count[0], 4);

        // low counter word wraps without carry into the upper bits
        abort_session(0);
        iv = IVW;
        start_session(0);
        repeat (5) @(negedge aclk);
        chk("wrap_flag", ctr_wrap[0], 1);
        chk("wrap_ctr", gen_dut[0].u_dut.ctr, 128'hf0f1f2f3f4f5f6f7f8f9fafb_00000001);
        pt_v = '{128'h0, 128'h0, 128'h0, 128'h0};
        run_stream(0, 2, 1'b0, 1'b0, "wrap");
        chk("wrap_count", blk_count[0], 2);
        iv = IV;

        // single core with random output stalls
        start_session(1);
        load_f51();
        run_stream(1, 4, 1'b1, 1'b1, "nc1");
        chk("nc1_count", blk_count[1], 4);

        // four cores with stalls, then two reloading packets
        start_session(2);
        load_f51();
        run_stream(2, 4, 1'b1, 1'b1, "nc4");
        pt_v  = '{PT0, PT1, PT0, PT1};
        exp_v = '{CT0, CT1, CT0, CT1};
        last_v = '{1'b0, 1'b1, 1'b0, 1'b1};
        run_stream(2, 4, 1'b1, 1'b1, "reload");
        chk("reload_count", blk_count[2], 8);

        // reset mid-operation
        @(negedge aclk) aresetn = 1'b0;
        @(negedge aclk) aresetn = 1'b1;
        chk("rst2_busy", busy, 0);
        chk("rst2_wrap", ctr_wrap[0], 0);
        chk("rst2_count", blk_count[2], 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
